data_cache: RTL and testbench

//  Direct-mapped, write-through, no-write-allocate data cache between the memory-stage

---
 rtl/dcache_pkg.sv | 22 ++
 rtl/dcache_load_align.sv | 27 ++
 rtl/data_cache.sv | 214 +++++++++++++++++++++
 tb/tb_data_cache.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and constants for the direct-mapped write-through data cache.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REFILL   = 2'd1,
        WRITE    = 2'd2,
        UNCACHED = 2'd3
    } state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [31:0] UNCACHED_LIMIT_DEFAULT = 32'h0000_0100;

endpackage

// File: rtl/dcache_load_align.sv
// Byte/half/word lane select with sign or zero extension.
module dcache_load_align
    import dcache_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[8*offset_i +: 8];
        half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];
        case (funct3_i)
            F3_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   data_o = {{16{half_sel[15]}}, half_sel};
            F3_LW:   data_o = word_i;
            F3_LBU:  data_o = {24'h0, byte_sel};
            F3_LHU:  data_o = {16'h0, half_sel};
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with line refill
// over a single-outstanding req/ack memory port; low addresses bypass the cache.
module data_cache
    import dcache_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned SETS           = 64,
    parameter int unsigned LINE_WORDS     = 4,
    parameter logic [31:0] UNCACHED_LIMIT = UNCACHED_LIMIT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [31:0]           cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wd,
    input  logic [2:0]            cpu_funct3,
    output logic [DATA_WIDTH-1:0] cpu_rd,
    output logic                  cpu_stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [31:0]           mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wd,
    output logic [2:0]            mem_funct3,
    input  logic [DATA_WIDTH-1:0] mem_rd,
    input  logic                  mem_ack
);

    localparam int unsigned WW = $clog2(LINE_WORDS);
    localparam int unsigned IW = $clog2(SETS);
    localparam int unsigned TW = 32 - 2 - WW - IW;
    localparam logic [WW-1:0] LAST_BEAT = WW'(LINE_WORDS - 1);

    logic [DATA_WIDTH-1:0] data_q [SETS][LINE_WORDS];
    logic [TW-1:0]         tag_q  [SETS];
    logic [SETS-1:0]       valid_q;

    state_t                state_q, state_d;
    logic [WW-1:0]         beat_q, beat_d, beat_nxt;
    logic                  mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [31:0]           mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wd_q, mem_wd_d;
    logic [2:0]            mem_funct3_q, mem_funct3_d;

    logic [WW-1:0]         word;
    logic [IW-1:0]         idx;
    logic [TW-1:0]         tag;
    logic                  hit, cacheable, fill_we, store_we;
    logic [DATA_WIDTH-1:0] ld_word, ld_data, st_clean, st_rep, st_merged;
    logic [2:0]            st_f3;
    logic [3:0]            st_be;

    assign word      = cpu_addr[2 +: WW];
    assign idx       = cpu_addr[2+WW +: IW];
    assign tag       = cpu_addr[31 -: TW];
    assign hit       = valid_q[idx] && (tag_q[idx] == tag);
    assign cacheable = (cpu_addr >= UNCACHED_LIMIT);
    assign ld_word   = data_q[idx][word];
    assign beat_nxt  = beat_q + WW'(1);

    dcache_load_align u_ld_align (
        .word_i   (ld_word),
        .offset_i (cpu_addr[1:0]),
        .funct3_i (cpu_funct3),
        .data_o   (ld_data)
    );

    // Store data is first trimmed to its access size by reusing the load aligner
    // with the matching zero-extending load, then replicated across lanes.
    assign st_f3 = (cpu_funct3 == F3_SW) ? F3_LW : {1'b1, cpu_funct3[1:0]};

    dcache_load_align u_st_align (
        .word_i   (cpu_wd),
        .offset_i (2'b00),
        .funct3_i (st_f3),
        .data_o   (st_clean)
    );

    always_comb begin
        st_rep = st_clean;
        st_be  = 4'b0000;
        case (cpu_funct3)
            F3_SB: begin
                st_rep = {4{st_clean[7:0]}};
                st_be  = 4'b0001 << cpu_addr[1:0];
            end
            F3_SH: begin
                st_rep = {2{st_clean[15:0]}};
                st_be  = cpu_addr[1] ? 4'b1100 : 4'b0011;
            end
            F3_SW:   st_be = 4'b1111;
            default: ;
        endcase
        st_merged = ld_word;
        for (int unsigned i = 0; i < 4; i++) begin
            if (st_be[i]) st_merged[8*i +: 8] = st_rep[8*i +: 8];
        end
    end

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wd_d     = mem_wd_q;
        mem_funct3_d = mem_funct3_q;
        cpu_stall    = 1'b0;
        cpu_rd       = '0;
        fill_we      = 1'b0;
        store_we     = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    if (cpu_we) begin
                        cpu_stall    = 1'b1;
                        state_d      = WRITE;
                        mem_req_d    = 1'b1;
                        mem_we_d     = 1'b1;
                        mem_addr_d   = cpu_addr;
                        mem_wd_d     = cpu_wd;
                        mem_funct3_d = cpu_funct3;
                    end else if (!cacheable) begin
                        cpu_stall    = 1'b1;
                        state_d      = UNCACHED;
                        mem_req_d    = 1'b1;
                        mem_we_d     = 1'b0;
                        mem_addr_d   = cpu_addr;
                        mem_funct3_d = cpu_funct3;
                    end else if (hit) begin
                        cpu_rd = ld_data;
                    end else begin
                        cpu_stall    = 1'b1;
                        state_d      = REFILL;
                        beat_d       = '0;
                        mem_req_d    = 1'b1;
                        mem_we_d     = 1'b0;
                        mem_addr_d   = {cpu_addr[31:2+WW], {(WW+2){1'b0}}};
                        mem_funct3_d = F3_LW;
                    end
                end
            end
            REFILL: begin
                cpu_stall = cpu_req;
                if (mem_ack) begin
                    fill_we = 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        state_d   = IDLE;
                        beat_d    = '0;
                        mem_req_d = 1'b0;
                    end else begin
                        beat_d     = beat_nxt;
                        mem_addr_d = {cpu_addr[31:2+WW], beat_nxt, 2'b00};
                    end
                end
            end
            WRITE: begin
                cpu_stall = cpu_req;
                if (mem_ack) begin
                    cpu_stall = 1'b0;
                    store_we  = cacheable && hit;
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                end
            end
            UNCACHED: begin
                cpu_stall = cpu_req;
                if (mem_ack) begin
                    cpu_stall = 1'b0;
                    cpu_rd    = mem_rd;
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            beat_q       <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wd_q     <= '0;
            mem_funct3_q <= '0;
            valid_q      <= '0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wd_q     <= mem_wd_d;
            mem_funct3_q <= mem_funct3_d;
            if (fill_we && (beat_q == LAST_BEAT)) valid_q[idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_we) data_q[idx][beat_q] <= mem_rd;
        if (fill_we && (beat_q == LAST_BEAT)) tag_q[idx] <= tag;
        if (store_we) data_q[idx][word] <= st_merged;
    end

    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wd     = mem_wd_q;
    assign mem_funct3 = mem_funct3_q;

endmodule

// File: tb/tb_data_cache.sv
// Bench for data_cache: directed scenarios then random traffic, checked against a
// flat memory model plus a record of which line each set currently holds.
module tb_data_cache;
    import dcache_pkg::*;

    logic        clk = 1'b0, rst = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wd = '0;
    logic [2:0]  cpu_funct3 = '0;
    logic [31:0] cpu_rd, mem_addr, mem_wd;
    logic        cpu_stall, mem_req, mem_we;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_rd = '0;
    logic        mem_ack = 1'b0;

    int checks = 0, errors = 0;

    data_cache #(.DATA_WIDTH(32), .SETS(64), .LINE_WORDS(4), .UNCACHED_LIMIT(32'h100)) dut (
        .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wd(cpu_wd), .cpu_funct3(cpu_funct3), .cpu_rd(cpu_rd), .cpu_stall(cpu_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
        .mem_funct3(mem_funct3), .mem_rd(mem_rd), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    logic [31:0] mem_aa [logic [31:0]];
    logic [31:0] cached [int unsigned];
    logic [31:0] rd_addr[$], wr_addr[$], wr_wd[$];
    logic [2:0]  wr_f3[$];
    int          fixed_delay = 1, cur_delay = 0, wcnt = 0;
    bit          rand_delay = 0, busy = 0;
    logic [31:0] bases [5] = '{32'h10000, 32'h20000, 32'h10040, 32'h7FFC0, 32'h000C0};

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] k;
        k = a & ~32'h3;
        if (mem_aa.exists(k)) return mem_aa[k];
        return (k * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic void mem_store(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3);
        logic [31:0] w, m;
        w = mem_word(a);
        if (f3 == 3'b000) begin
            m = 32'hFF << (8 * a[1:0]);
            w = (w & ~m) | ((wd & 32'hFF) << (8 * a[1:0]));
        end else if (f3 == 3'b001) begin
            m = 32'hFFFF << (16 * a[1]);
            w = (w & ~m) | ((wd & 32'hFFFF) << (16 * a[1]));
        end else if (f3 == 3'b010) begin
            w = wd;
        end
        mem_aa[a & ~32'h3] = w;
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] a, input logic [2:0] f3);
        logic [31:0] w, b, h;
        w = mem_word(a);
        b = (w >> (8 * a[1:0])) & 32'hFF;
        h = (w >> (16 * a[1])) & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 32'd128) ? b - 32'd256 : b;
            3'b001:  return (h >= 32'd32768) ? h - 32'd65536 : h;
            3'b010:  return w;
            3'b100:  return b;
            3'b101:  return h;
            default: return 32'h0;
        endcase
    endfunction

    // Backing memory: each request is acked after a programmable number of cycles.
    always @(posedge clk) begin
        #1;
        mem_ack = 1'b0;
        mem_rd  = $urandom;
        if (rst || !mem_req) begin
            busy = 0;
        end else begin
            if (!busy) begin
                busy = 1;
                wcnt = 0;
                cur_delay = rand_delay ? int'($urandom_range(0, 3)) : fixed_delay;
            end
            if (wcnt == cur_delay) begin
                mem_ack = 1'b1;
                busy = 0;
                if (mem_we) begin
                    wr_addr.push_back(mem_addr);
                    wr_wd.push_back(mem_wd);
                    wr_f3.push_back(mem_funct3);
                    mem_store(mem_addr, mem_wd, mem_funct3);
                end else begin
                    rd_addr.push_back(mem_addr);
                    mem_rd = mem_word(mem_addr);
                end
            end else begin
                wcnt++;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", nm, obs, exp);
        end
    endtask

    task automatic access(input string nm, input logic we, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [2:0] f3);
        logic [31:0] exp, line;
        int unsigned set;
        bit unc, miss, done;
        int stalls, nr0, nw0, exp_stall, exp_rd, exp_wr;
        unc  = addr < 32'h100;
        line = addr & ~32'hF;
        set  = (addr >> 4) & 63;
        miss = !unc && !(cached.exists(set) && cached[set] == line);
        exp  = unc ? mem_word(addr) : exp_load(addr, f3);
        nr0  = rd_addr.size();
        nw0  = wr_addr.size();
        @(posedge clk); #2;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wd = wd; cpu_funct3 = f3;
        stalls = 0;
        done = 0;
        while (!done && stalls <= 200) begin
            @(negedge clk);
            if (cpu_stall === 1'b0) done = 1;
            else stalls++;
        end
        chk($sformatf("%s_done", nm), 32'(done), 32'd1);
        if (!we) chk($sformatf("%s_rd@%h", nm, addr), cpu_rd, exp);
        if (!we && !unc && !miss) exp_stall = 0;
        else if (!we && !unc) exp_stall = 4 * (fixed_delay + 1) + 1;
        else exp_stall = fixed_delay + 1;
        if (!rand_delay || exp_stall == 0) chk($sformatf("%s_stalls", nm), 32'(stalls), 32'(exp_stall));
        @(posedge clk); #2;
        cpu_req = 1'b0;
        @(negedge clk);
        exp_rd = we ? 0 : (unc ? 1 : (miss ? 4 : 0));
        exp_wr = we ? 1 : 0;
        chk($sformatf("%s_nreads", nm), 32'(rd_addr.size() - nr0), 32'(exp_rd));
        chk($sformatf("%s_nwrites", nm), 32'(wr_addr.size() - nw0), 32'(exp_wr));
        if (exp_rd == 4 && rd_addr.size() >= nr0 + 4)
            for (int k = 0; k < 4; k++)
                chk($sformatf("%s_beat%0d_addr", nm, k), rd_addr[nr0 + k], line + 32'(4 * k));
        if (exp_rd == 1 && rd_addr.size() > nr0)
            chk($sformatf("%s_unc_addr", nm), rd_addr[nr0], addr);
        if (we && wr_addr.size() > nw0) begin
            chk($sformatf("%s_wr_addr", nm), wr_addr[nw0], addr);
            chk($sformatf("%s_wr_wd", nm), wr_wd[nw0], wd);
            chk($sformatf("%s_wr_f3", nm), 32'(wr_f3[nw0]), 32'(f3));
        end
        chk($sformatf("%s_idle_req", nm), 32'(mem_req), 32'd0);
        chk($sformatf("%s_idle_stall", nm), 32'(cpu_stall), 32'd0);
        chk($sformatf("%s_idle_rd", nm), cpu_rd, 32'd0);
        if (!we && !unc && miss) cached[set] = line;
    endtask

    initial begin
        int waited;
        mem_aa[32'h10000] = 32'h1122_3344;
        mem_aa[32'h10004] = 32'h8001_8084;
        mem_aa[32'h10008] = 32'hCAFE_F00D;
        mem_aa[32'h1000C] = 32'h0BAD_BEEF;
        mem_aa[32'h000FC] = 32'h0000_0001;

        repeat (2) @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wd", mem_wd, 32'd0);
        chk("rst_mem_f3", 32'(mem_funct3), 32'd0);
        chk("rst_stall", 32'(cpu_stall), 32'd0);
        chk("rst_rd", cpu_rd, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        access("lw_miss", 1'b0, 32'h10000, 32'h0, F3_LW);
        chk("lw_miss_value", exp_load(32'h10000, F3_LW), 32'h1122_3344);
        access("lw_hit", 1'b0, 32'h10008, 32'h0, F3_LW);
        access("lb_hit", 1'b0, 32'h10003, 32'h0, F3_LB);
        access("lbu_hit", 1'b0, 32'h10004, 32'h0, F3_LBU);
        access("lb_neg", 1'b0, 32'h10004, 32'h0, F3_LB);
        access("lh_neg", 1'b0, 32'h10006, 32'h0, F3_LH);
        access("lhu_hit", 1'b0, 32'h10006, 32'h0, F3_LHU);
        access("bad_f3", 1'b0, 32'h10008, 32'h0, 3'b011);
        access("sb_hit", 1'b1, 32'h10001, 32'hDEAD_BEAB, F3_SB);
        access("lw_after_sb", 1'b0, 32'h10000, 32'h0, F3_LW);
        access("sh_hit", 1'b1, 32'h1000E, 32'h5555_1234, F3_SH);
        access("lw_after_sh", 1'b0, 32'h1000C, 32'h0, F3_LW);
        access("sw_miss", 1'b1, 32'h20000, 32'h5566_7788, F3_SW);
        access("lw_after_sw", 1'b0, 32'h20000, 32'h0, F3_LW);
        access("unc_lw1", 1'b0, 32'h000FC, 32'h0, F3_LW);
        access("unc_lw2", 1'b0, 32'h000FC, 32'h0, F3_LW);

        // Reset while the third beat of a refill is outstanding.
        @(posedge clk); #2;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h30000; cpu_funct3 = F3_LW;
        waited = 0;
        while (mem_addr !== 32'h30008 && waited < 50) begin
            @(posedge clk); #2;
            waited++;
        end
        chk("mid_rst_beat2", mem_addr, 32'h30008);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_mem_req", 32'(mem_req), 32'd0);
        chk("mid_rst_mem_addr", mem_addr, 32'd0);
        chk("mid_rst_stall", 32'(cpu_stall), 32'd1);
        cpu_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        cached.delete();
        access("post_rst_refill", 1'b0, 32'h30000, 32'h0, F3_LW);
        access("post_rst_old", 1'b0, 32'h10000, 32'h0, F3_LW);

        rand_delay = 1;
        for (int i = 0; i < 300; i++) begin
            logic [31:0] base, addr, wd;
            logic [2:0]  f3;
            logic        we;
            int          sz, u;
            base = bases[$urandom_range(0, 4)];
            we   = ($urandom_range(0, 3) == 0);
            sz   = $urandom_range(0, 2);
            u    = $urandom_range(0, 1);
            wd   = $urandom;
            addr = base + 32'(4 * $urandom_range(0, 3));
            if (sz == 0) addr = addr + 32'($urandom_range(0, 3));
            else if (sz == 1) addr = addr + 32'(2 * $urandom_range(0, 1));
            if (we) f3 = 3'(sz);
            else if (base < 32'h100) begin
                f3 = F3_LW;
                addr = addr & ~32'h3;
            end else if (sz == 2) f3 = F3_LW;
            else f3 = 3'(sz) | ((u == 1) ? 3'b100 : 3'b000);
            access($sformatf("rnd%0d", i), we, addr, wd, f3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
